seq_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle datapath ALU, for the next-generation CPU datapath.
- Executes one operation per transaction on WIDTH-bit operands. Single-cycle ops finish in one execute cycle; shift/rotate-by-N and multiply are multi-cycle.
- Holds a registered Z|C|N|V flag register that the control unit can optionally update per operation.
- Sits between the register file/operand muxes and the write-back path, using valid/ready on both sides.

---
 rtl/seq_alu.sv | 178 +++++++++++++++++
 tb/tb_seq_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts/rotate,
// and a shift-add multiplier, with a registered {Z,C,N,V} flag register.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             flag_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [SHW-1:0] SH_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] MUL_CNT = SHW'(WIDTH - 1);

    state_t           state_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, acc_r, lo_r;
    logic [SHW-1:0]   n_r, cnt_r;
    logic             fen_r;

    logic             accept_s, cin_s, c_s, v_s, shout_s;
    logic [WIDTH:0]   add_s, sub_s, madd_s;
    logic [WIDTH-1:0] res_s, acc_nx_s, lo_nx_s, shift_s;
    logic [SHW-1:0]   n_in_s;

    assign in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s = in_valid && in_ready;
    assign n_in_s   = input_b[SHW-1:0];

    // Execute-cycle datapath: next shift/multiply state and the final result/flag values
    always_comb begin
        cin_s    = (op_r == 4'h5) && flags[2];
        add_s    = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_s};
        sub_s    = {1'b0, a_r} - {1'b0, b_r};
        // Multiplier: {acc_r, lo_r} is the product shifting right, lo_r[0] selects the add
        madd_s   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        shift_s  = acc_r;
        shout_s  = 1'b0;
        case (op_r)
            4'hB: begin shift_s = {acc_r[WIDTH-2:0], 1'b0};          shout_s = acc_r[WIDTH-1]; end
            4'hC: begin shift_s = {1'b0, acc_r[WIDTH-1:1]};          shout_s = acc_r[0];       end
            4'hD: begin shift_s = {acc_r[WIDTH-1], acc_r[WIDTH-1:1]}; shout_s = acc_r[0];      end
            4'hE: begin shift_s = {acc_r[WIDTH-2:0], acc_r[WIDTH-1]}; shout_s = acc_r[WIDTH-1]; end
            default: begin shift_s = acc_r; shout_s = 1'b0; end
        endcase
        acc_nx_s = acc_r;
        lo_nx_s  = lo_r;
        res_s    = {WIDTH{1'b0}};
        c_s      = flags[2];
        v_s      = 1'b0;
        case (op_r)
            4'h0: res_s = a_r;
            4'h1: res_s = b_r;
            4'h2: res_s = ~a_r;
            4'h3: res_s = ~b_r;
            4'h4, 4'h5: begin
                res_s = add_s[WIDTH-1:0];
                c_s   = add_s[WIDTH];
                v_s   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            4'h6: begin
                res_s = sub_s[WIDTH-1:0];
                c_s   = ~sub_s[WIDTH];
                v_s   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            4'h7: res_s = a_r & b_r;
            4'h8: res_s = a_r | b_r;
            4'h9: res_s = a_r ^ b_r;
            4'hA: res_s = ~(a_r & b_r);
            4'hB, 4'hC, 4'hD, 4'hE: begin
                if (n_r == {SHW{1'b0}}) begin
                    res_s = a_r;
                end else begin
                    acc_nx_s = shift_s;
                    res_s    = shift_s;
                    c_s      = shout_s;
                end
            end
            4'hF: begin
                acc_nx_s = madd_s[WIDTH:1];
                lo_nx_s  = {madd_s[0], lo_r[WIDTH-1:1]};
                res_s    = lo_nx_s;
                v_s      = |acc_nx_s;
            end
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM, operand capture and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            op_r      <= 4'h0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            n_r       <= {SHW{1'b0}};
            cnt_r     <= {SHW{1'b0}};
            fen_r     <= 1'b0;
            result    <= {WIDTH{1'b0}};
            flags     <= 4'h0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r <= EXEC;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    acc_r <= acc_nx_s;
                    lo_r  <= lo_nx_s;
                    if (cnt_r == {SHW{1'b0}}) begin
                        result    <= res_s;
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        if (fen_r) begin
                            flags <= {(res_s == {WIDTH{1'b0}}), c_s, res_s[WIDTH-1], v_s};
                        end else begin
                            flags <= flags;
                        end
                    end else begin
                        cnt_r <= cnt_r - SH_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= in_valid ? EXEC : IDLE;
                        busy      <= in_valid;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
            if (accept_s) begin
                op_r  <= op;
                a_r   <= input_a;
                b_r   <= input_b;
                fen_r <= flag_en;
                n_r   <= n_in_s;
                acc_r <= (op == 4'hF) ? {WIDTH{1'b0}} : input_a;
                lo_r  <= input_b;
                if (op == 4'hF) begin
                    cnt_r <= MUL_CNT;
                end else if ((op >= 4'hB) && (n_in_s != {SHW{1'b0}})) begin
                    cnt_r <= n_in_s - SH_ONE;
                end else begin
                    cnt_r <= {SHW{1'b0}};
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus randomized bench for seq_alu (WIDTH=32) with an arithmetic reference model.
module tb_seq_alu;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'h0;
    logic [31:0] input_a = 32'h0;
    logic [31:0] input_b = 32'h0;
    logic        flag_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mflags = 4'h0;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
    int          exp_cyc;
    logic [31:0] held;

    seq_alu #(.WIDTH(32), .SHW(5)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .input_a(input_a), .input_b(input_b), .flag_en(flag_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: result, flags and execute-cycle count from the operation rules
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] fi, input logic fe,
                         output logic [31:0] r, output logic [3:0] f, output int cyc);
        logic [63:0] w;
        int n;
        logic c, v;
        n = int'(b[4:0]);
        c = fi[2];
        v = 1'b0;
        cyc = 1;
        r = 32'h0;
        case (o)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = ~a;
            4'h3: r = ~b;
            4'h4, 4'h5: begin
                w = {32'h0, a} + {32'h0, b} + ((o == 4'h5) ? {63'h0, fi[2]} : 64'h0);
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h6: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h7: r = a & b;
            4'h8: r = a | b;
            4'h9: r = a ^ b;
            4'hA: r = ~(a & b);
            4'hB: begin r = a << n; if (n > 0) c = a[32-n]; end
            4'hC: begin r = a >> n; if (n > 0) c = a[n-1]; end
            4'hD: begin r = $unsigned($signed(a) >>> n); if (n > 0) c = a[n-1]; end
            4'hE: begin
                r = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
                if (n > 0) c = r[0];
            end
            default: begin
                w = {32'h0, a} * {32'h0, b};
                r = w[31:0];
                v = |w[63:32];
                cyc = 32;
            end
        endcase
        if (o >= 4'hB && o <= 4'hE) cyc = (n == 0) ? 1 : n;
        f = fe ? {(r == 32'h0), c, r[31], v} : fi;
    endtask

    // Called at a negedge: present an op and wait for the accepting edge
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic fe);
        model(o, a, b, mflags, fe, exp_res, exp_flags, exp_cyc);
        in_valid = 1'b1; op = o; input_a = a; input_b = b; flag_en = fe;
        chk("in_ready_at_issue", {63'h0, in_ready}, 64'h1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        input_a = $urandom; input_b = $urandom; op = 4'($urandom); flag_en = 1'($urandom);
    endtask

    // Wait (bounded) for out_valid, checking latency, busy duration, result and flags
    task automatic collect();
        int lat = 0;
        int bcnt = 0;
        do begin
            @(negedge clock);
            lat++;
            if (busy) bcnt++;
        end while (!out_valid && lat < 200);
        chk("latency", 64'(lat), 64'(exp_cyc + 1));
        chk("busy_cycles", 64'(bcnt), 64'(exp_cyc));
        chk("result", {32'h0, result}, {32'h0, exp_res});
        chk("flags", {60'h0, flags}, {60'h0, exp_flags});
        mflags = exp_flags;
    endtask

    initial begin
        #2;
        chk("rst_result", {32'h0, result}, 64'h0);
        chk("rst_flags", {60'h0, flags}, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        issue(4'h4, 32'hFFFF_FFFF, 32'h1, 1'b1); collect();
        chk("add_flags_const", {60'h0, flags}, 64'hC);
        @(negedge clock);
        issue(4'h6, 32'h8000_0000, 32'h1, 1'b1); collect();
        chk("sub_res_const", {32'h0, result}, 64'h7FFF_FFFF);
        chk("sub_flags_const", {60'h0, flags}, 64'h5);
        issue(4'h5, 32'h1, 32'h1, 1'b1); collect();
        chk("adc_res_const", {32'h0, result}, 64'h3);
        @(negedge clock);
        issue(4'hD, 32'h8000_0000, 32'h4, 1'b1); collect();
        chk("asr_res_const", {32'h0, result}, 64'hF800_0000);
        @(negedge clock);
        issue(4'hB, 32'h1, 32'h0, 1'b1); collect();
        chk("lsl0_res_const", {32'h0, result}, 64'h1);
        @(negedge clock);
        issue(4'hF, 32'h0001_0000, 32'h0001_0000, 1'b1); collect();
        chk("mul_flags_const", {60'h0, flags}, 64'h9);

        @(negedge clock);
        out_ready = 1'b0;
        issue(4'h9, 32'h1234_5678, 32'h1234_5678, 1'b0); collect();
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
            chk("bp_result", {32'h0, result}, {32'h0, held});
            chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
        end
        chk("bp_flags_held", {60'h0, flags}, 64'h9);
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_released", {63'h0, out_valid}, 64'h0);
        issue(4'hF, 32'd7, 32'd6, 1'b1); collect();
        chk("mul42_const", {32'h0, result}, 64'd42);

        @(negedge clock);
        issue(4'h6, 32'h8000_0000, 32'h1, 1'b1); collect();
        @(negedge clock);
        issue(4'hF, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_result", {32'h0, result}, 64'h0);
        chk("midrst_flags", {60'h0, flags}, 64'h0);
        chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        mflags = 4'h0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        issue(4'h4, 32'd2, 32'd3, 1'b1); collect();
        chk("post_rst_add", {32'h0, result}, 64'd5);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clock);
            issue(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
            collect();
        end
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
